// File: rtl/dff_pattern_sequencer_pkg.sv
// dff_seq_pkg: shared types and helpers for the DFF pattern sequencer.
//   state_e     - sequencer FSM states
//   busy_cycles - cycles busy stays high for one sequence (w*h shift + 1 drain)
package dff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int busy_cycles(input int w, input int h);
    return w * h + 1;
  endfunction

endpackage

// File: rtl/dff_pattern_sequencer_if.sv
// Sequencer bus: config/handshake from the test master plus the DFF d/q pair.
//   master: drives start, abort, lsb_first, pattern and the DFF q (q_in)
//   slave : the sequencer; drives ser_d, busy, done, capture, mismatch
interface dff_pattern_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             lsb_first;
  logic [WIDTH-1:0] pattern;
  logic             ser_d;
  logic             q_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] capture;
  logic             mismatch;

  modport master (
    output start, abort, lsb_first, pattern, q_in,
    input  ser_d, busy, done, capture, mismatch
  );

  modport slave (
    input  start, abort, lsb_first, pattern, q_in,
    output ser_d, busy, done, capture, mismatch
  );
endinterface

// File: rtl/dff_pattern_sequencer_hold_timer.sv
// hold_timer: counts the cycles a pattern bit has been held on ser_d.
//   clk, rst_n  - clock, async active-low reset
//   clr_i       - restart count (sequence start or abort)
//   en_i        - count while shifting
//   bit_last_o  - high on the final hold cycle of the current bit
module hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_last_o
);
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(HOLD_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign bit_last_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)           cnt_d = '0;
    else if (bit_last_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dff_pattern_sequencer.sv
// dff_pattern_sequencer: drives a latched parallel pattern bit-serially onto an
// external DFF, holding each bit HOLD_CYCLES cycles, captures the DFF's q one
// cycle behind and flags any difference at completion.
//   clk, rst_n - clock, async active-low reset
//   bus        - slave side of dff_pattern_sequencer_if (start/abort/config in,
//                ser_d to DFF, q_in from DFF, busy/done/capture/mismatch out)
module dff_pattern_sequencer
  import dff_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dff_pattern_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH * HOLD_CYCLES + 1);
  localparam int IDX_W = $clog2(WIDTH);
  // cycle count of the final SHIFT cycle, relative to the start edge
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(busy_cycles(WIDTH, HOLD_CYCLES) - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             lsb_q, lsb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  // capture pending: q_in this cycle belongs to bit capidx_q
  logic             capv_q, capv_d;
  logic [IDX_W-1:0] capidx_q, capidx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             mis_q, mis_d;
  logic             tmr_clr, bit_last;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr),
    .en_i       (state_q == SHIFT),
    .bit_last_o (bit_last)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    lsb_d    = lsb_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    capv_d   = 1'b0;
    capidx_d = capidx_q;
    shadow_d = shadow_q;
    cap_d    = cap_q;
    mis_d    = mis_q;
    tmr_clr  = 1'b0;

    if (capv_q) shadow_d[capidx_q] = bus.q_in;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          pat_d    = bus.pattern;
          lsb_d    = bus.lsb_first;
          idx_d    = bus.lsb_first ? '0 : IDX_W'(WIDTH - 1);
          cyc_d    = '0;
          shadow_d = '0;
          tmr_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
          if (bit_last) begin
            capv_d   = 1'b1;
            capidx_d = idx_q;
            if (cyc_q == LAST_SHIFT) state_d = DRAIN;
            else idx_d = lsb_q ? idx_q + 1'b1 : idx_q - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          // shadow_d already holds the final bit taken this cycle
          state_d = DONE;
          cap_d   = shadow_d;
          mis_d   = (shadow_d != pat_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      lsb_q    <= 1'b0;
      idx_q    <= '0;
      cyc_q    <= '0;
      capv_q   <= 1'b0;
      capidx_q <= '0;
      shadow_q <= '0;
      cap_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      lsb_q    <= lsb_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      capv_q   <= capv_d;
      capidx_q <= capidx_d;
      shadow_q <= shadow_d;
      cap_q    <= cap_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT) || (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);
  assign bus.ser_d    = bus.busy ? pat_q[idx_q] : 1'b0;
  assign bus.capture  = cap_q;
  assign bus.mismatch = mis_q;
endmodule

// File: tb/tb_dff_pattern_sequencer.sv
module tb_dff_pattern_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      t_start = '0, t_abort = '0, t_lsb = '0, t_stuck = '0;
  logic [1:0][7:0] t_pat = '0;
  logic [1:0]      dff_q;
  logic [1:0]      q_in;

  dff_pattern_sequencer_if #(.WIDTH(8)) if0 ();
  dff_pattern_sequencer_if #(.WIDTH(8)) if1 ();

  dff_pattern_sequencer #(.WIDTH(8), .HOLD_CYCLES(1)) u_h1 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dff_pattern_sequencer #(.WIDTH(8), .HOLD_CYCLES(3)) u_h3 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.start = t_start[0]; assign if0.abort = t_abort[0];
  assign if0.lsb_first = t_lsb[0]; assign if0.pattern = t_pat[0];
  assign if1.start = t_start[1]; assign if1.abort = t_abort[1];
  assign if1.lsb_first = t_lsb[1]; assign if1.pattern = t_pat[1];

  // ideal external DFF, optionally stuck at 0
  always @(posedge clk or negedge rst_n)
    if (!rst_n) dff_q <= '0;
    else        dff_q <= {if1.ser_d, if0.ser_d};
  assign q_in = dff_q & ~t_stuck;
  assign if0.q_in = q_in[0];
  assign if1.q_in = q_in[1];

  logic [1:0]      act_ser, act_busy, act_done, act_mis;
  logic [1:0][7:0] act_cap;
  assign act_ser  = {if1.ser_d, if0.ser_d};
  assign act_busy = {if1.busy, if0.busy};
  assign act_done = {if1.done, if0.done};
  assign act_mis  = {if1.mismatch, if0.mismatch};
  assign act_cap  = {if1.capture, if0.capture};

  logic [1:0]      exp_ser, exp_busy, exp_done, exp_mis;
  logic [1:0][7:0] exp_cap;

  // Behavioural model: k = cycles since the accepted start edge.
  // k in [0, 8H) shift, k = 8H drain, k = 8H+1 done; k = -1 idle.
  for (genvar g = 0; g < 2; g++) begin : m
    localparam int H  = (g == 0) ? 1 : 3;
    localparam int WH = 8 * H;
    int         k;
    logic [7:0] mp;
    logic       ml;
    logic       qs [0:WH+1];
    logic [7:0] mcap;
    logic       mmis;
    logic       e_ser, e_busy, e_done, e_mis;
    logic [7:0] e_cap;
    int         j;

    // bit j (in send order) is read from q_in during cycle (j+1)*H
    function automatic logic [7:0] build();
      logic [7:0] c;
      c = '0;
      for (int b = 0; b < 8; b++) c[ml ? b : 7 - b] = qs[(b + 1) * H];
      return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        k <= -1; mcap <= '0; mmis <= 1'b0; mp <= '0; ml <= 1'b0;
      end else if (k < 0) begin
        if (t_start[g]) begin k <= 0; mp <= t_pat[g]; ml <= t_lsb[g]; end
      end else if (t_abort[g] && k <= WH) begin
        k <= -1;
      end else begin
        qs[k] <= q_in[g];
        if (k == WH + 1) begin
          k <= -1; mcap <= build(); mmis <= (build() != mp);
        end else k <= k + 1;
      end
    end

    always_comb begin
      j      = 0;
      e_busy = (k >= 0) && (k <= WH);
      e_done = (k == WH + 1);
      e_ser  = 1'b0;
      if (e_busy) begin
        j     = (k / H > 7) ? 7 : k / H;
        e_ser = mp[ml ? j : 7 - j];
      end
      e_cap = e_done ? build() : mcap;
      e_mis = e_done ? (build() != mp) : mmis;
    end

    assign exp_ser[g] = e_ser;  assign exp_busy[g] = e_busy;
    assign exp_done[g] = e_done; assign exp_mis[g] = e_mis;
    assign exp_cap[g] = e_cap;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, g, a, e, $time);
    end
  endtask

  // every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("ser_d", g, 32'(act_ser[g]), 32'(exp_ser[g]));
      chk("busy", g, 32'(act_busy[g]), 32'(exp_busy[g]));
      chk("done", g, 32'(act_done[g]), 32'(exp_done[g]));
      chk("capture", g, 32'(act_cap[g]), 32'(exp_cap[g]));
      chk("mismatch", g, 32'(act_mis[g]), 32'(exp_mis[g]));
    end
  end

  // directed sequence with hand-computed expectations
  task automatic run(input int g, input logic [7:0] p, input logic l, input logic s,
                     input int h, input logic [7:0] e_seq, input logic [7:0] e_cap,
                     input logic e_mis);
    int n, nb; logic got; logic [7:0] sq;
    @(posedge clk); #1;
    t_start[g] = 1'b1; t_pat[g] = p; t_lsb[g] = l; t_stuck[g] = s;
    @(posedge clk); #1;
    t_start[g] = 1'b0; t_pat[g] = ~p; t_lsb[g] = ~l;
    n = 0; nb = 0; got = 1'b0; sq = '0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (act_busy[g]) begin
        if (n % h == 0 && n < 8 * h) sq = {sq[6:0], act_ser[g]};
        nb++;
      end
      n++;
      if (act_done[g]) got = 1'b1;
    end
    chk("done_seen", g, 32'(got), 32'd1);
    chk("busy_len", g, nb, 8 * h + 1);
    chk("latency", g, n - 1, 8 * h + 1);
    chk("ser_seq", g, 32'(sq), 32'(e_seq));
    chk("cap_lit", g, 32'(act_cap[g]), 32'(e_cap));
    chk("mis_lit", g, 32'(act_mis[g]), 32'(e_mis));
  endtask

  initial begin
    int nd;
    @(negedge clk);
    chk("rst_busy", 0, 32'(act_busy[0]), 0);
    chk("rst_ser", 0, 32'(act_ser[0]), 0);
    chk("rst_cap", 0, 32'(act_cap[0]), 0);
    chk("rst_mis", 0, 32'(act_mis[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run(0, 8'hA5, 1'b1, 1'b0, 1, 8'hA5, 8'hA5, 1'b0);
    run(0, 8'h81, 1'b0, 1'b0, 1, 8'h81, 8'h81, 1'b0);
    run(1, 8'hF0, 1'b1, 1'b0, 3, 8'h0F, 8'hF0, 1'b0);
    run(0, 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    chk("cap_held", 0, 32'(act_cap[0]), 32'h00);
    chk("mis_held", 0, 32'(act_mis[0]), 1);
    t_stuck[0] = 1'b0;

    // clean run with a start pulse while busy: one done only
    @(posedge clk); #1 t_start[0] = 1'b1; t_pat[0] = 8'h5A; t_lsb[0] = 1'b0;
    @(posedge clk); #1 t_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 t_start[0] = 1'b1; t_pat[0] = 8'h00;
    @(posedge clk); #1 t_start[0] = 1'b0;
    nd = 0;
    repeat (20) begin @(negedge clk); if (act_done[0]) nd++; end
    chk("one_done", 0, nd, 1);
    chk("cap_5a", 0, 32'(act_cap[0]), 32'h5A);

    // abort during 4th shift cycle
    @(posedge clk); #1 t_start[0] = 1'b1; t_pat[0] = 8'hFF;
    @(posedge clk); #1 t_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 t_abort[0] = 1'b1;
    @(posedge clk); #1 t_abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_idle", 0, 32'(act_busy[0]), 0);
    nd = 0;
    repeat (15) begin @(negedge clk); if (act_done[0]) nd++; end
    chk("abort_nodone", 0, nd, 0);
    chk("abort_cap", 0, 32'(act_cap[0]), 32'h5A);
    chk("abort_mis", 0, 32'(act_mis[0]), 0);

    // async reset mid-shift
    @(posedge clk); #1 t_start[0] = 1'b1; t_pat[0] = 8'hFF; t_lsb[0] = 1'b1;
    @(posedge clk); #1 t_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 0, 32'(act_busy[0]), 1);
    chk("pre_rst_ser", 0, 32'(act_ser[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(act_busy[0]), 0);
    chk("arst_ser", 0, 32'(act_ser[0]), 0);
    chk("arst_cap", 0, 32'(act_cap[0]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run(0, 8'hA5, 1'b1, 1'b0, 1, 8'hA5, 8'hA5, 1'b0);

    // random traffic on both sequencers, model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        t_start[g] = ($urandom_range(0, 3) == 0);
        t_pat[g]   = 8'($urandom);
        t_lsb[g]   = 1'($urandom_range(0, 1));
        t_abort[g] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 15) == 0) t_stuck[g] = ~t_stuck[g];
      end
      rst_n = ($urandom_range(0, 799) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; t_start = '0; t_abort = '0; t_stuck = '0;
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
